// File: rtl/muldiv_pkg.sv
// muldiv_pkg: M-extension funct3 codes, controller states and op-class helper
package muldiv_pkg;
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX request/response and iterative-unit handshake bundle
interface muldiv_if;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flushE;
  logic        unit_start;
  logic        unit_kill;
  logic [2:0]  unit_funct3;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [31:0] unit_result;
  logic        stall_ex;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        busy;
  modport slave (
    input  req_valid, req_funct3, req_a, req_b, flushE, unit_result,
    output unit_start, unit_kill, unit_funct3, unit_a, unit_b,
           stall_ex, resp_valid, resp_result, busy
  );
  modport master (
    output req_valid, req_funct3, req_a, req_b, flushE, unit_result,
    input  unit_start, unit_kill, unit_funct3, unit_a, unit_b,
           stall_ex, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/muldiv_special.sv
// muldiv_special: RISC-V divide-by-zero and signed-overflow results resolved without the unit
import muldiv_pkg::*;
module muldiv_special (
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_is_special,
  output logic [31:0] o_special_result
);
  logic w_dz, w_ovf;
  always_comb begin
    w_dz = is_div(i_funct3) && i_b == '0;
    w_ovf = is_div(i_funct3) && !i_funct3[0] && i_a == 32'h8000_0000 && i_b == '1;
    o_is_special = w_dz | w_ovf;
    o_special_result = w_dz ? (i_funct3[1] ? i_a : '1) : (w_ovf && !i_funct3[1]) ? 32'h8000_0000 : '0;
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issues M-extension ops to the shared iterative unit, freezes EX for
// its fixed latency and hands the result to EX/MEM for exactly one cycle
import muldiv_pkg::*;
module muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [31:0]       r_res, w_res, w_spec_res;
  logic              w_spec, w_issue, w_abort;
  muldiv_special u_special (
    .i_funct3         (bus.req_funct3),
    .i_a              (bus.req_a),
    .i_b              (bus.req_b),
    .o_is_special     (w_spec),
    .o_special_result (w_spec_res)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_res <= w_res;
    end
  // combinational outputs are gated by reset so they read 0 while it is held
  always_comb begin
    w_issue = r_state == IDLE && bus.req_valid && !bus.flushE && !reset;
    w_abort = r_state == RUN && (bus.flushE || !bus.req_valid);
    w_next = r_state;
    w_cnt = r_cnt;
    w_res = r_res;
    case (r_state)
      IDLE: if (w_issue) begin
        w_next = w_spec ? DONE : RUN;
        w_cnt = is_div(bus.req_funct3) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        w_res = w_spec_res;
      end
      RUN: if (w_abort) w_next = IDLE;
        else if (r_cnt == '0) begin
          w_next = DONE;
          w_res = bus.unit_result;
        end else w_cnt = r_cnt - CNT_W'(1);
      default: w_next = IDLE;
    endcase
    bus.unit_start = w_issue && !w_spec;
    bus.unit_kill = w_abort;
    bus.unit_funct3 = bus.unit_start ? bus.req_funct3 : '0;
    bus.unit_a = bus.unit_start ? bus.req_a : '0;
    bus.unit_b = bus.unit_start ? bus.req_b : '0;
    bus.stall_ex = bus.req_valid && !bus.flushE && r_state != DONE && !reset;
    bus.resp_valid = r_state == DONE;
    bus.resp_result = r_state == DONE ? r_res : '0;
    bus.busy = r_state != IDLE;
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: vector table, randomized ops against an arithmetic reference, flush/reset sequences
import muldiv_pkg::*;
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  logic clk, reset;
  int n_pass, n_tot;
  muldiv_if bus();
  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (f3)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      DIV:    return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
      DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
      REM:    return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    bit sp;
    int lat;
    sp = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat = sp ? 0 : (f3[2] ? DIV_LAT : MUL_LAT);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      bus.req_valid = 1; bus.req_funct3 = f3; bus.req_a = a; bus.req_b = b; bus.flushE = 0;
      bus.unit_result = (k == lat && !sp) ? exp : exp ^ ($urandom | 1);
      #1;
      if (k == 0) begin
        chk("start", {31'b0, bus.unit_start}, {31'b0, !sp});
        chk("unit_a", bus.unit_a, sp ? 0 : a);
        chk("unit_b", bus.unit_b, sp ? 0 : b);
        chk("unit_f3", {29'b0, bus.unit_funct3}, sp ? 0 : {29'b0, f3});
      end else if (k <= lat) chk("no_restart", {31'b0, bus.unit_start}, 0);
      if (k <= lat) begin
        chk("stall", {30'b0, bus.stall_ex, bus.resp_valid}, 2'b10);
        chk("result_idle", bus.resp_result, 0);
      end else begin
        chk("resp", {28'b0, bus.stall_ex, bus.resp_valid, bus.busy, bus.unit_start}, 4'b0110);
        chk("result", bus.resp_result, exp);
      end
    end
  endtask
  task automatic idle_chk();
    @(negedge clk);
    bus.req_valid = 0; bus.flushE = 0;
    #1;
    chk("idle", {29'b0, bus.busy, bus.stall_ex, bus.resp_valid}, 0);
  endtask
  initial begin
    logic [2:0] f3;
    logic [31:0] a, b;
    n_pass = 0; n_tot = 0;
    tbl[0]  = '{DIVU,   32'h0000_1234, 32'h0,          32'hFFFF_FFFF};
    tbl[1]  = '{REMU,   32'h0000_1234, 32'h0,          32'h0000_1234};
    tbl[2]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000};
    tbl[3]  = '{REM,    32'h8000_0000, 32'hFFFF_FFFF,  32'h0};
    tbl[4]  = '{DIV,    32'h0000_0009, 32'h0,          32'hFFFF_FFFF};
    tbl[5]  = '{REM,    32'h0000_0005, 32'h0,          32'h0000_0005};
    tbl[6]  = '{MUL,    32'h0000_0003, 32'h0000_0005,  32'h0000_000F};
    tbl[7]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE};
    tbl[8]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0};
    tbl[9]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    tbl[10] = '{DIVU,   32'd100,       32'd7,          32'd14};
    tbl[11] = '{DIV,    32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFD};
    tbl[12] = '{REM,    32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF};
    tbl[13] = '{MUL,    32'h0001_0000, 32'h0001_0000,  32'h0};
    reset = 1;
    bus.req_valid = 1; bus.req_funct3 = MUL; bus.req_a = 3; bus.req_b = 5;
    bus.flushE = 0; bus.unit_result = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", {27'b0, bus.unit_start, bus.unit_kill, bus.stall_ex, bus.resp_valid, bus.busy}, 0);
    chk("reset_res", bus.resp_result, 0);
    @(negedge clk);
    reset = 0; bus.req_valid = 0;
    run_op(MUL, 3, 5, 15);
    idle_chk();
    foreach (tbl[i]) run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp);
    idle_chk();
    run_op(MUL, 3, 5, 15);
    run_op(DIVU, 100, 7, 14);
    idle_chk();
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(f3, a, b, ref_result(f3, a, b));
      if ($urandom_range(0, 1) == 1) idle_chk();
    end
    idle_chk();
    @(negedge clk);
    bus.req_valid = 1; bus.req_funct3 = DIV; bus.req_a = 1000; bus.req_b = 3; bus.unit_result = 0;
    #1;
    chk("flush_start", {31'b0, bus.unit_start}, 1);
    for (int k = 1; k < 30; k++) @(negedge clk);
    bus.flushE = 1;
    #1;
    chk("flush_kill", {30'b0, bus.unit_kill, bus.stall_ex}, 2'b10);
    @(negedge clk);
    bus.flushE = 0; bus.req_valid = 0;
    #1;
    chk("flush_idle", {29'b0, bus.busy, bus.resp_valid, bus.unit_kill}, 0);
    @(negedge clk);
    bus.unit_result = 333;
    #1;
    chk("late_result", {31'b0, bus.resp_valid}, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("late_quiet", {bus.busy, bus.resp_valid, bus.resp_result[29:0]}, 0);
    end
    @(negedge clk);
    bus.req_valid = 1; bus.req_funct3 = MUL; bus.req_a = 2; bus.req_b = 2;
    #1;
    chk("drop_start", {31'b0, bus.unit_start}, 1);
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    #1;
    chk("drop_kill", {30'b0, bus.unit_kill, bus.stall_ex}, 2'b10);
    @(negedge clk);
    #1;
    chk("drop_idle", {29'b0, bus.busy, bus.unit_kill, bus.resp_valid}, 0);
    @(negedge clk);
    bus.req_valid = 1; bus.flushE = 1; bus.req_funct3 = DIV; bus.req_b = 0;
    #1;
    chk("flush_noissue", {30'b0, bus.unit_start, bus.stall_ex}, 0);
    @(negedge clk);
    #1;
    chk("flush_nobusy", {30'b0, bus.busy, bus.resp_valid}, 0);
    @(negedge clk);
    bus.flushE = 0; bus.req_funct3 = MUL; bus.req_a = 9; bus.req_b = 9;
    #1;
    chk("rst_start", {31'b0, bus.unit_start}, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_async", {27'b0, bus.unit_start, bus.unit_kill, bus.stall_ex, bus.resp_valid, bus.busy}, 0);
    chk("rst_res", bus.resp_result, 0);
    @(negedge clk);
    reset = 0; bus.req_valid = 0;
    run_op(MUL, 7, 6, 42);
    idle_chk();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
